gps_bpsk_modulator: RTL and testbench
=====================================

Name: gps_bpsk_modulator

Overview:
Downstream stage of the 1-bit carrier NCO in the GPS signal generator. Takes the NCO's 1-bit sin/cos carrier, the C/A code chip stream and navigation data words. It serialises the nav data at one bit per EPOCHS_PER_BIT code epochs, aligned to epoch boundaries. It then BPSK-modulates the carrier with chip XOR data bit to produce registered 1-bit I/Q outputs.

Parameters:
EPOCHS_PER_BIT, 20, C/A code epochs per navigation data bit (GPS L1: 20 ms / 1 ms)
WORD_BITS, 30, navigation word length in bits, shifted out MSB first
CNT_W, 5, epoch counter width; must satisfy 2**CNT_W >= EPOCHS_PER_BIT

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ena  input  1  clock enable; when 0 all state and outputs hold
cos_in  input  1  NCO cosine (carrier I)
sin_in  input  1  NCO sine (carrier Q)
code_chip  input  1  current C/A chip, 0/1
code_epoch  input  1  one-cycle pulse; marks the cycle carrying chip 0 of a C/A period
word_data  input  WORD_BITS  navigation word
word_valid  input  1  word_data valid
word_ready  output  1  holding register empty (combinational, = ~hold_full)
mod_i  output  1  registered cos_in XOR sym
mod_q  output  1  registered sin_in XOR sym
data_bit  output  1  registered nav bit currently applied
bit_strobe  output  1  registered one-cycle pulse on the first output using a new data bit
underrun  output  1  sticky: word exhausted with no word waiting

Behaviour:
- Reset: state=IDLE, hold_full=0, shift reg=0, epoch_cnt=0, bit_idx=0. mod_i, mod_q, data_bit, bit_strobe, underrun all 0. word_ready=1 during and after reset.
- ena=0: no register changes, no word accepted. word_ready still reflects hold_full.
- Accept: word_valid & word_ready & ena -> hold<=word_data, hold_full<=1, underrun<=0.
  - word_ready=0 while hold_full, so accept and hold-transfer never coincide.
- Boundary event (B), evaluated only when ena & code_epoch:
  - IDLE with hold_full: B=1 (start).
  - RUN with epoch_cnt==EPOCHS_PER_BIT-1: B=1.
  - Otherwise in RUN: epoch_cnt+1.
  - IDLE without hold_full: nothing; epoch_cnt stays 0.
- On B in RUN, epoch_cnt<=0 and:
  - bit_idx<WORD_BITS-1: shift reg left by 1, bit_idx+1.
  - bit_idx==WORD_BITS-1 and hold_full: load hold into shift, bit_idx<=0, hold_full<=0.
  - bit_idx==WORD_BITS-1 and hold empty: state<=IDLE, underrun<=1, effective bit 0.
- On B in IDLE (start): load hold into shift, bit_idx=0, epoch_cnt=0, hold_full<=0, state<=RUN.
- Effective bit eb: the bit in effect after the B update, i.e. new shift MSB (0 if going IDLE) on a B cycle, else the current applied bit. In IDLE, eb=0.
- Each ena cycle, with sym = code_chip XOR eb:
  - mod_i<=cos_in XOR sym; mod_q<=sin_in XOR sym; data_bit<=eb.
  - Latency: 1 cycle from inputs to outputs.
  - The new bit applies to the chip-0 cycle of its epoch, so data transitions are exactly epoch-aligned.
- bit_strobe<=B & (state after B == RUN); otherwise 0.
- Underrun: sticky until the next accepted word. A waiting word restarts transmission at the next code_epoch, not the next bit boundary.
- Reset mid-word: the word in flight and the held word are discarded.

Test Plan:
Use EPOCHS_PER_BIT=2, WORD_BITS=4 unless stated; code_epoch every 4 cycles; ena=1.
- Reset: assert rst mid-run -> all outputs 0 and word_ready=1 immediately (async); after release, no strobes until a word is accepted.
- Idle passthrough: no word, code_chip toggling, cos_in=1, sin_in=0 -> mod_i = ~code_chip, mod_q = code_chip, one cycle later; data_bit=0.
- Serialisation: accept 4'b1011 -> first strobe on the output after the next code_epoch; data_bit sequence 1,0,1,1, each held for exactly 2 epochs (8 cycles); word_ready returns to 1 the cycle after start.
- Back-to-back: accept 4'b1011 then 4'b0100 while the first runs -> 8 contiguous bits 1,0,1,1,0,1,0,0, no gap, underrun stays 0.
- Underrun: single word, no follow-up -> after the last bit, data_bit=0, underrun=1 at the boundary; a new word clears underrun on accept and restarts at the next code_epoch.
- ena gating: drop ena for 3 cycles, including a code_epoch -> that epoch not counted, outputs frozen, bit duration extended by one epoch.

Source files
------------

// File: rtl/gps_bpsk_modulator_if.sv
// Carrier/code/nav-word inputs and modulated I/Q outputs of the BPSK modulator.
// master drives the carrier, code and word handshake; slave is the modulator.
interface gps_bpsk_modulator_if #(
  parameter int WORD_BITS = 30
);
  logic                 ena;
  logic                 cos_in;
  logic                 sin_in;
  logic                 code_chip;
  logic                 code_epoch;
  logic [WORD_BITS-1:0] word_data;
  logic                 word_valid;
  logic                 word_ready;
  logic                 mod_i;
  logic                 mod_q;
  logic                 data_bit;
  logic                 bit_strobe;
  logic                 underrun;

  modport master (
    output ena, cos_in, sin_in, code_chip, code_epoch, word_data, word_valid,
    input  word_ready, mod_i, mod_q, data_bit, bit_strobe, underrun
  );

  modport slave (
    input  ena, cos_in, sin_in, code_chip, code_epoch, word_data, word_valid,
    output word_ready, mod_i, mod_q, data_bit, bit_strobe, underrun
  );
endinterface

// File: rtl/gps_bpsk_modulator.sv
// Serialises nav words at one bit per EPOCHS_PER_BIT code epochs and BPSK-modulates the 1-bit carrier.
// Latency 1 cycle inputs->I/Q; word_ready drops while a word is held, freeing when it moves to the shifter.
module gps_bpsk_modulator #(
  parameter int EPOCHS_PER_BIT = 20,
  parameter int WORD_BITS      = 30,
  parameter int CNT_W          = 5
) (
  input logic                 clk,
  input logic                 rst,
  gps_bpsk_modulator_if.slave bus
);
  localparam int IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EPOCHS_PER_BIT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_n;
  logic [WORD_BITS-1:0] hold, hold_n;
  logic [WORD_BITS-1:0] shift, shift_n;
  logic                 hold_full, hold_full_n;
  logic [CNT_W-1:0]     epoch_cnt, epoch_cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic                 underrun_q, underrun_n;
  logic                 mod_i_q, mod_q_q, data_bit_q, strobe_q;
  logic                 epoch_ev, accept, bnd, eb, sym, strobe_n;

  assign bus.word_ready = ~hold_full;
  assign epoch_ev       = bus.ena & bus.code_epoch;
  assign accept         = bus.ena & bus.word_valid & ~hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.ena) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shift_n     = shift;
    epoch_cnt_n = epoch_cnt;
    bit_idx_n   = bit_idx;
    underrun_n  = underrun_q;
    bnd         = 1'b0;

    case (state)
      IDLE: begin
        if (epoch_ev && hold_full) begin
          bnd         = 1'b1;
          state_n     = RUN;
          shift_n     = hold;
          bit_idx_n   = '0;
          epoch_cnt_n = '0;
          hold_full_n = 1'b0;
        end
      end
      RUN: begin
        if (epoch_ev) begin
          if (epoch_cnt == LAST_CNT) begin
            bnd         = 1'b1;
            epoch_cnt_n = '0;
            if (bit_idx != LAST_IDX) begin
              shift_n   = shift << 1;
              bit_idx_n = bit_idx + 1'b1;
            end else if (hold_full) begin
              shift_n     = hold;
              bit_idx_n   = '0;
              hold_full_n = 1'b0;
            end else begin
              state_n    = IDLE;
              underrun_n = 1'b1;
            end
          end else begin
            epoch_cnt_n = epoch_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Accept only happens with the hold register empty, so it never races the hold->shift transfer.
    if (accept) begin
      hold_n      = bus.word_data;
      hold_full_n = 1'b1;
      underrun_n  = 1'b0;
    end

    // Using the post-boundary bit puts each data transition on the chip-0 cycle of its epoch.
    eb       = (state_n == RUN) ? shift_n[WORD_BITS-1] : 1'b0;
    sym      = bus.code_chip ^ eb;
    strobe_n = bnd && (state_n == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      epoch_cnt  <= '0;
      bit_idx    <= '0;
      underrun_q <= 1'b0;
      mod_i_q    <= 1'b0;
      mod_q_q    <= 1'b0;
      data_bit_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else if (bus.ena) begin
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      shift      <= shift_n;
      epoch_cnt  <= epoch_cnt_n;
      bit_idx    <= bit_idx_n;
      underrun_q <= underrun_n;
      mod_i_q    <= bus.cos_in ^ sym;
      mod_q_q    <= bus.sin_in ^ sym;
      data_bit_q <= eb;
      strobe_q   <= strobe_n;
    end
  end

  assign bus.mod_i      = mod_i_q;
  assign bus.mod_q      = mod_q_q;
  assign bus.data_bit   = data_bit_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_gps_bpsk_modulator.sv
// Directed bench: EPOCHS_PER_BIT=2, WORD_BITS=4, code_epoch every 4th cycle.
module tb_gps_bpsk_modulator;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   ph;
  logic lc, ls, lch;

  gps_bpsk_modulator_if #(.WORD_BITS(4)) bus ();

  gps_bpsk_modulator #(
    .EPOCHS_PER_BIT(2),
    .WORD_BITS     (4),
    .CNT_W         (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs {cos,sin,chip,epoch,valid}, word, expected {mod_i,mod_q,data_bit,strobe,underrun,ready}
  typedef struct packed {
    logic [4:0] in_b;
    logic [3:0] dat;
    logic [5:0] exp_b;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [4:0] in_b, input logic [3:0] dat, input logic [5:0] exp_b);
    vec_t v;
    v.in_b  = in_b;
    v.dat   = dat;
    v.exp_b = exp_b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t ph=%0d got=%b expected=%b", nm, $time, ph, act, exp);
    end
  endtask

  // One enabled-or-frozen cycle on the free-running epoch grid, then compare all outputs.
  task automatic step(input logic vld, input logic [3:0] dat, input logic en,
                      input logic e_bit, input logic e_stb, input logic e_unr, input logic e_rdy);
    logic [31:0] p;
    p              = ph;
    bus.ena        = en;
    bus.word_valid = vld;
    bus.word_data  = dat;
    bus.code_epoch = (ph % 4 == 0);
    bus.cos_in     = p[1];
    bus.sin_in     = p[0] ^ p[2];
    bus.code_chip  = 1'($urandom_range(0, 1));
    if (en) begin
      lc  = bus.cos_in;
      ls  = bus.sin_in;
      lch = bus.code_chip;
    end
    @(posedge clk);
    #1;
    chk("mod_i", bus.mod_i, lc ^ lch ^ e_bit);
    chk("mod_q", bus.mod_q, ls ^ lch ^ e_bit);
    chk("data_bit", bus.data_bit, e_bit);
    chk("bit_strobe", bus.bit_strobe, e_stb);
    chk("underrun", bus.underrun, e_unr);
    chk("word_ready", bus.word_ready, e_rdy);
    ph++;
  endtask

  initial begin
    logic [3:0] w1;
    logic [7:0] b2b;
    logic       e_bit;
    int         idx;

    total = 0;
    bad   = 0;
    ph    = 0;
    lc    = 1'b0;
    ls    = 1'b0;
    lch   = 1'b0;
    w1    = 4'b1011;
    b2b   = 8'b1101_0100;

    tbl[0]  = mk(5'b10010, 4'h0,    6'b100001);
    tbl[1]  = mk(5'b10100, 4'h0,    6'b010001);
    tbl[2]  = mk(5'b10000, 4'h0,    6'b100001);
    tbl[3]  = mk(5'b10100, 4'h0,    6'b010001);
    tbl[4]  = mk(5'b01110, 4'h0,    6'b100001);
    tbl[5]  = mk(5'b11001, 4'b1011, 6'b110000);
    tbl[6]  = mk(5'b00101, 4'b0000, 6'b110000);
    tbl[7]  = mk(5'b10000, 4'h0,    6'b100000);
    tbl[8]  = mk(5'b01010, 4'h0,    6'b101101);
    tbl[9]  = mk(5'b01100, 4'h0,    6'b011001);
    tbl[10] = mk(5'b11100, 4'h0,    6'b111001);
    tbl[11] = mk(5'b00000, 4'h0,    6'b111001);

    rst            = 1'b1;
    bus.ena        = 1'b1;
    bus.cos_in     = 1'b0;
    bus.sin_in     = 1'b0;
    bus.code_chip  = 1'b0;
    bus.code_epoch = 1'b0;
    bus.word_data  = 4'h0;
    bus.word_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mod_i", bus.mod_i, 1'b0);
    chk("rst_mod_q", bus.mod_q, 1'b0);
    chk("rst_data_bit", bus.data_bit, 1'b0);
    chk("rst_strobe", bus.bit_strobe, 1'b0);
    chk("rst_underrun", bus.underrun, 1'b0);
    chk("rst_ready", bus.word_ready, 1'b1);
    rst = 1'b0;

    // Idle passthrough, accept 1011, start on the next epoch.
    for (int r = 0; r < 12; r++) begin
      bus.cos_in     = tbl[r].in_b[4];
      bus.sin_in     = tbl[r].in_b[3];
      bus.code_chip  = tbl[r].in_b[2];
      bus.code_epoch = tbl[r].in_b[1];
      bus.word_valid = tbl[r].in_b[0];
      bus.word_data  = tbl[r].dat;
      @(posedge clk);
      #1;
      chk("tbl_mod_i", bus.mod_i, tbl[r].exp_b[5]);
      chk("tbl_mod_q", bus.mod_q, tbl[r].exp_b[4]);
      chk("tbl_data_bit", bus.data_bit, tbl[r].exp_b[3]);
      chk("tbl_strobe", bus.bit_strobe, tbl[r].exp_b[2]);
      chk("tbl_underrun", bus.underrun, tbl[r].exp_b[1]);
      chk("tbl_ready", bus.word_ready, tbl[r].exp_b[0]);
    end

    // Rest of 1011 (first bit already 4 cycles in), then underrun at the last boundary.
    ph = 0;
    for (int i = 0; i < 32; i++) begin
      idx   = (i + 4) / 8;
      e_bit = (idx < 4) ? w1[3 - idx] : 1'b0;
      step(1'b0, 4'h0, 1'b1, e_bit, (idx >= 1) && (idx <= 3) && ((i + 4) % 8 == 0), idx >= 4, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // New word clears underrun, restarts on the next epoch; second word queued -> 8 contiguous bits.
    step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 64; j++) begin
      step(j == 2, 4'b0100, 1'b1, b2b[7 - j / 8], j % 8 == 0, 1'b0, (j < 2) || (j >= 32));
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

    // ena low for 3 cycles across an epoch: outputs freeze, no accept, first bit lasts 3 epochs.
    step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) begin
      e_bit = (k < 12) ? 1'b1 : ((k < 20) ? 1'b0 : 1'b1);
      step((k == 4) || (k == 14), 4'b0011, !((k >= 3) && (k <= 5)), e_bit,
           (k == 0) || (k == 12) || (k == 20), 1'b0, k < 14);
    end

    // Asynchronous reset mid-word with a word held: everything clears before any clock edge.
    rst = 1'b1;
    #2;
    chk("arst_mod_i", bus.mod_i, 1'b0);
    chk("arst_mod_q", bus.mod_q, 1'b0);
    chk("arst_data_bit", bus.data_bit, 1'b0);
    chk("arst_strobe", bus.bit_strobe, 1'b0);
    chk("arst_underrun", bus.underrun, 1'b0);
    chk("arst_ready", bus.word_ready, 1'b1);
    @(posedge clk);
    #1;
    ph++;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
